// File: rtl/frame_scheduler_if.sv
// rtl/frame_scheduler_if.sv - source, encoder and serializer signals of the frame scheduler
interface frame_scheduler_if #(
  parameter int RATE = 2
);
  localparam int SW = (RATE > 1) ? $clog2(RATE) : 1;

  logic          start;
  logic          abort;
  logic          in_bit;
  logic          busy;
  logic          done;
  logic          in_req;
  logic          enc_clear;
  logic          enc_shift;
  logic          enc_bit;
  logic          out_strobe;
  logic [SW-1:0] out_sel;

  modport master (
    input  start, abort, in_bit,
    output busy, done, in_req, enc_clear, enc_shift, enc_bit, out_strobe, out_sel
  );

  modport slave (
    output start, abort, in_bit,
    input  busy, done, in_req, enc_clear, enc_shift, enc_bit, out_strobe, out_sel
  );
endinterface

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - slot timing and frame sequencing for the convolutional encoder
module frame_scheduler #(
  parameter int DIV        = 4,
  parameter int RATE       = 2,
  parameter int FRAME_BITS = 8,
  parameter int TAIL_BITS  = 2
) (
  input  logic               clk,
  input  logic               rst,
  frame_scheduler_if.master  bus
);
  localparam int DW    = $clog2(DIV);
  localparam int SW    = (RATE > 1) ? $clog2(RATE) : 1;
  localparam int TOTAL = FRAME_BITS + TAIL_BITS;
  localparam int BW    = $clog2(TOTAL + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(RATE - 1);
  localparam logic [BW-1:0] DATA_END  = BW'(FRAME_BITS);
  localparam logic [BW-1:0] TAIL_END  = BW'(TOTAL);

  typedef enum logic [2:0] {IDLE, CLEAR, DATA, TAIL, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          enc_bit_q, enc_bit_d;

  logic          busy, done, in_req, enc_clear, enc_shift, out_strobe;
  logic [SW-1:0] out_sel;
  logic          period_end;
  logic [BW-1:0] bit_next;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    slot_d     = slot_q;
    bit_cnt_d  = bit_cnt_q;
    enc_bit_d  = enc_bit_q;
    busy       = (state_q != IDLE);
    done       = 1'b0;
    in_req     = 1'b0;
    enc_clear  = 1'b0;
    enc_shift  = 1'b0;
    out_strobe = 1'b0;
    out_sel    = '0;
    period_end = (div_cnt_q == DIV_LAST) && (slot_q == SLOT_LAST);
    bit_next   = bit_cnt_q + BW'(1);

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) state_d = CLEAR;
      end
      CLEAR: begin
        enc_clear = 1'b1;
        div_cnt_d = '0;
        slot_d    = '0;
        bit_cnt_d = '0;
        state_d   = DATA;
      end
      DATA, TAIL: begin
        in_req     = (state_q == DATA) && (slot_q == '0) && (div_cnt_q == '0);
        enc_shift  = (slot_q == '0) && (div_cnt_q == DW'(1));
        out_strobe = (div_cnt_q == DIV_LAST);
        out_sel    = out_strobe ? slot_q : '0;
        if (enc_shift) enc_bit_d = (state_q == DATA) ? bus.in_bit : 1'b0;
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
        if (div_cnt_q == DIV_LAST) slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
        // bit_cnt keeps counting through the tail so one counter marks both phase ends
        if (period_end) begin
          bit_cnt_d = bit_next;
          if (state_q == DATA && bit_next == DATA_END) state_d = (TAIL_BITS == 0) ? DONE : TAIL;
          if (state_q == TAIL && bit_next == TAIL_END) state_d = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        div_cnt_d = '0;
        slot_d    = '0;
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      enc_bit_d = 1'b0;
      if (state_q != IDLE) begin
        state_d    = IDLE;
        div_cnt_d  = '0;
        slot_d     = '0;
        bit_cnt_d  = '0;
        done       = 1'b0;
        in_req     = 1'b0;
        enc_clear  = 1'b0;
        enc_shift  = 1'b0;
        out_strobe = 1'b0;
        out_sel    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      slot_q    <= '0;
      bit_cnt_q <= '0;
      enc_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      slot_q    <= slot_d;
      bit_cnt_q <= bit_cnt_d;
      enc_bit_q <= enc_bit_d;
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.in_req     = in_req;
  assign bus.enc_clear  = enc_clear;
  assign bus.enc_shift  = enc_shift;
  assign bus.enc_bit    = enc_bit_q;
  assign bus.out_strobe = out_strobe;
  assign bus.out_sel    = out_sel;
endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - randomized frame scheduler bench with cycle-offset reference model
module tb_frame_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_scheduler_if #(.RATE(2)) if0();
  frame_scheduler_if #(.RATE(3)) if1();

  frame_scheduler #(.DIV(4), .RATE(2), .FRAME_BITS(8), .TAIL_BITS(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  frame_scheduler #(.DIV(3), .RATE(3), .FRAME_BITS(1), .TAIL_BITS(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int p_div  [2] = '{4, 3};
  int p_rate [2] = '{2, 3};
  int p_fb   [2] = '{8, 1};
  int p_tb   [2] = '{2, 0};

  logic start_v [2] = '{1'b0, 1'b0};
  logic abort_v [2] = '{1'b0, 1'b0};
  logic in_bit_v[2] = '{1'b0, 1'b0};

  assign if0.start  = start_v[0];
  assign if0.abort  = abort_v[0];
  assign if0.in_bit = in_bit_v[0];
  assign if1.start  = start_v[1];
  assign if1.abort  = abort_v[1];
  assign if1.in_bit = in_bit_v[1];

  // {busy, done, in_req, enc_clear, enc_shift, enc_bit, out_strobe, out_sel[1:0]}
  logic [8:0] ob [2];
  assign ob[0] = {if0.busy, if0.done, if0.in_req, if0.enc_clear, if0.enc_shift,
                  if0.enc_bit, if0.out_strobe, 1'b0, if0.out_sel};
  assign ob[1] = {if1.busy, if1.done, if1.in_req, if1.enc_clear, if1.enc_shift,
                  if1.enc_bit, if1.out_strobe, if1.out_sel};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  bit m_act [2] = '{1'b0, 1'b0};
  int m_fs  [2] = '{0, 0};
  bit m_eb  [2] = '{1'b0, 1'b0};
  bit fbits [2][16];
  bit fixed_next [2] = '{1'b0, 1'b0};
  bit fixed_pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  int req_idx [2] = '{0, 0};
  bit req_pend[2] = '{1'b0, 1'b0};
  bit src_val [2] = '{1'b0, 1'b0};
  int n_req[2], n_sh[2], n_st[2], n_cl[2];

  // Expected outputs follow from the offset of the current cycle from the accepted start
  always @(negedge clk) if (chk_en) begin
    for (int d = 0; d < 2; d++) begin
      int D, R, F, T, L, t, u, per, r, sl, dv;
      logic [8:0] e;
      bit ab, nb;
      D = p_div[d]; R = p_rate[d]; F = p_fb[d]; T = p_tb[d];
      L = (F + T) * R * D;
      ab = abort_v[d];
      t = cyc - m_fs[d];
      per = 0;
      nb = 1'b0;
      e = '0;
      e[8] = m_act[d];
      if (m_act[d] && !ab) begin
        if (t == 1) e[5] = 1'b1;
        if (t >= 2 && t < 2 + L) begin
          u = t - 2; per = u / (R * D); r = u % (R * D); sl = r / D; dv = r % D;
          e[6] = (per < F) && (sl == 0) && (dv == 0);
          e[4] = (sl == 0) && (dv == 1);
          e[2] = (dv == D - 1);
          if (e[2]) e[1:0] = sl[1:0];
        end
        if (t == 2 + L) e[7] = 1'b1;
      end
      e[3] = m_eb[d];

      check($sformatf("d%0d_busy", d),       ob[d][8],   e[8]);
      check($sformatf("d%0d_done", d),       ob[d][7],   e[7]);
      check($sformatf("d%0d_in_req", d),     ob[d][6],   e[6]);
      check($sformatf("d%0d_enc_clear", d),  ob[d][5],   e[5]);
      check($sformatf("d%0d_enc_shift", d),  ob[d][4],   e[4]);
      check($sformatf("d%0d_enc_bit", d),    ob[d][3],   e[3]);
      check($sformatf("d%0d_out_strobe", d), ob[d][2],   e[2]);
      check($sformatf("d%0d_out_sel", d),    ob[d][1:0], e[1:0]);

      if (ob[d][6]) n_req[d]++;
      if (ob[d][4]) n_sh[d]++;
      if (ob[d][2]) n_st[d]++;
      if (ob[d][5]) n_cl[d]++;
      if (ob[d][7]) begin
        check($sformatf("d%0d_done_cycle", d), cyc - m_fs[d], 2 + L);
        check($sformatf("d%0d_req_count", d),   n_req[d], F);
        check($sformatf("d%0d_shift_count", d), n_sh[d],  F + T);
        check($sformatf("d%0d_strobe_count", d), n_st[d], (F + T) * R);
        check($sformatf("d%0d_clear_count", d), n_cl[d],  1);
      end

      if (ob[d][6]) begin
        req_pend[d] = 1'b1;
        src_val[d]  = fbits[d][(req_idx[d] < 16) ? req_idx[d] : 15];
        req_idx[d]++;
      end else begin
        req_pend[d] = 1'b0;
      end

      if (e[4]) nb = (per < F) ? fbits[d][per] : 1'b0;
      if (rst || ab) m_eb[d] = 1'b0;
      else if (e[4]) m_eb[d] = nb;

      if (rst) begin
        m_act[d] = 1'b0;
      end else if (m_act[d] && ab) begin
        m_act[d] = 1'b0;
      end else if (m_act[d] && t == 2 + L) begin
        m_act[d] = 1'b0;
      end else if (!m_act[d] && start_v[d] && !ab) begin
        m_act[d] = 1'b1;
        m_fs[d] = cyc;
        n_req[d] = 0; n_sh[d] = 0; n_st[d] = 0; n_cl[d] = 0;
        req_idx[d] = 0;
        for (int i = 0; i < 16; i++)
          fbits[d][i] = (fixed_next[d] && i < 8) ? fixed_pat[i] : (fixed_next[d] ? 1'b0 : 1'($urandom));
        fixed_next[d] = 1'b0;
      end
    end
  end

  // Source answers one cycle after in_req; otherwise drives noise
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      in_bit_v[d] = req_pend[d] ? src_val[d] : 1'($urandom);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int d);
    start_v[d] = 1'b1;
    tick(1);
    start_v[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);

    fixed_next[0] = 1'b1;
    start_v[0] = 1'b1; start_v[1] = 1'b1;
    tick(1);
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    tick(100);

    pulse_start(0);
    tick(19);
    pulse_start(0);
    tick(80);

    pulse_start(0);
    tick(39);
    abort_v[0] = 1'b1;
    tick(1);
    abort_v[0] = 1'b0;
    tick(4);
    pulse_start(0);
    tick(90);

    start_v[0] = 1'b1; abort_v[0] = 1'b1; start_v[1] = 1'b1; abort_v[1] = 1'b1;
    tick(1);
    start_v[0] = 1'b0; abort_v[0] = 1'b0; start_v[1] = 1'b0; abort_v[1] = 1'b0;
    tick(5);

    pulse_start(0);
    tick(49);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    pulse_start(0);
    tick(90);

    start_v[0] = 1'b1; start_v[1] = 1'b1;
    tick(250);
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    tick(90);

    repeat (3000) begin
      for (int d = 0; d < 2; d++) begin
        start_v[d] = ($urandom % 16) == 0;
        abort_v[d] = ($urandom % 64) == 0;
      end
      rst = ($urandom % 500) == 0;
      tick(1);
    end
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    abort_v[0] = 1'b0; abort_v[1] = 1'b0;
    rst = 1'b0;
    tick(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Frame-level sequencer for the rate-1/RATE convolutional coding datapath. It divides the system clock into coded-bit slots and clears the encoder at frame start. It pulls FRAME_BITS information bits from the source with a request/data handshake, shifts each bit into the encoder, and appends TAIL_BITS zero flush bits. It also strobes each coded output bit to the downstream serializer/channel at a fixed slot rate.

## Interface
- DIV, 4: clock cycles per coded-bit slot; must be ≥ 3
- RATE, 2: coded bits per encoder shift (slots per information period); must be ≥ 1
- FRAME_BITS, 8: information bits per frame; must be ≥ 1
- TAIL_BITS, 2: zero flush bits after data (K−1); 0 allowed
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE
- abort  in  1  synchronous frame cancel; sampled in every state
- in_bit  in  1  information bit from source; valid the cycle after in_req
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal frame completion
- in_req  out  1  one-cycle request for the next information bit
- enc_clear  out  1  one-cycle encoder state clear
- enc_shift  out  1  one-cycle encoder shift enable
- enc_bit  out  1  bit to shift into encoder; registered
- out_strobe  out  1  one-cycle pulse: coded bit out_sel is valid
- out_sel  out  max(1,clog2(RATE))  index of coded bit being strobed

## Operation
- Reset values: every output 0, state IDLE, all counters 0.
- States: IDLE → CLEAR → DATA → TAIL → DONE → IDLE.
- IDLE: start=1 with abort=0 → CLEAR. start is ignored in any other state.
- CLEAR: lasts one cycle. enc_clear=1. Loads div_cnt=0, slot=0, bit_cnt=0, then → DATA.
- DATA/TAIL counters:
  - div_cnt counts 0..DIV−1 every cycle.
  - slot increments when div_cnt wraps, over the range 0..RATE−1.
  - bit_cnt increments when slot wraps at the end of an information period.
- Events within each information period, at slot 0:
  - div_cnt=0: in_req=1 (DATA only).
  - div_cnt=1: enc_bit is in_bit sampled this cycle in DATA, or 0 in TAIL. enc_shift=1 for this cycle.
- Strobe in every slot: at div_cnt=DIV−1, out_strobe=1 with out_sel=slot.
- enc_bit holds its value until the next enc_shift. It returns to 0 on reset or abort.
- DATA → TAIL after FRAME_BITS periods complete. If TAIL_BITS=0, DATA → DONE instead.
- TAIL → DONE after TAIL_BITS periods complete.
- DONE: lasts one cycle with done=1, then → IDLE.
- abort=1 in any non-IDLE state → IDLE next cycle. All pulses are suppressed that cycle, done is not asserted, and counters are cleared.
- rst has priority over abort and start.
- Counter widths: div_cnt clog2(DIV), slot clog2(RATE) (minimum 1), bit_cnt clog2(FRAME_BITS+TAIL_BITS+1). No counter exceeds its terminal value.

## Timing
- Start sampled in cycle 0: CLEAR in cycle 1. DATA begins in cycle 2, with in_req in cycle 2 and enc_shift in cycle 3.
- Information period length: RATE·DIV cycles. DATA+TAIL length: (FRAME_BITS+TAIL_BITS)·RATE·DIV cycles.
- DONE (done=1) occurs in cycle 2 + (FRAME_BITS+TAIL_BITS)·RATE·DIV. busy falls the next cycle.
- Source latency: exactly one cycle from in_req to valid in_bit. There is no stall or backpressure.
- Spacing: first out_strobe of a period is DIV−2 cycles after enc_shift, which allows encoder output to settle (DIV ≥ 3).
- Per frame: exactly FRAME_BITS in_req pulses, FRAME_BITS+TAIL_BITS enc_shift pulses, (FRAME_BITS+TAIL_BITS)·RATE out_strobe pulses, and one enc_clear pulse.
- Back-to-back frames: a start held high through DONE is accepted in the IDLE cycle that follows, giving a minimum 2-cycle gap between frames.

## Test plan
- Defaults, start pulse in cycle 0, in_bit pattern 1,0,1,1,0,0,1,0 → enc_clear in cycle 1; 8 in_req; 10 enc_shift with enc_bit 1,0,1,1,0,0,1,0,0,0; 20 out_strobe with out_sel alternating 0,1; done in cycle 82; busy=0 in cycle 83.
- Slot spacing: check in_req→enc_shift is 1 cycle, enc_shift→out_strobe(sel 0) is 2 cycles, and consecutive out_strobes are 4 cycles apart across the whole frame.
- abort asserted in cycle 40 → IDLE, busy=0 and enc_bit=0 in cycle 41; no done; no further pulses. A start in cycle 45 runs a full clean frame beginning with enc_clear.
- start re-pulsed at cycle 20 mid-frame → ignored; frame timing identical to the first test. start and abort both high in IDLE → remains IDLE.
- rst asserted in cycle 50 for one cycle → all outputs 0 the next cycle, state IDLE. A subsequent start behaves as from power-up.
- Parameter sweep (DIV=3, RATE=3, FRAME_BITS=1, TAIL_BITS=0) → 1 in_req, 1 enc_shift, out_sel 0,1,2, done in cycle 11.
